// File: rtl/calc_arbiter.sv
// Round-robin sharing of one combinational 4-bit calculator between two requesters.
// Sequencing is accept (IDLE) -> execute (EXEC) -> respond (RESP); completed responses are counted.
module calc_arbiter #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [W-1:0]     resp0_r,
  output logic             resp0_ovf,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [W-1:0]     resp1_r,
  output logic             resp1_ovf,

  output logic [2:0]       calc_op,
  output logic [W-1:0]     calc_a,
  output logic [W-1:0]     calc_b,
  input  logic [W-1:0]     calc_r,
  input  logic             calc_ovf,

  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic           last;     // requester served most recently
  logic           gnt;      // requester owning the current operation
  logic [W-1:0]   r_q;
  logic           ovf_q;
  logic           pick1;
  logic           resp_hs;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick1 = req1_valid & (~req0_valid | ~last);
  end

  assign req0_ready = (state == IDLE) & req0_valid & ~pick1;
  assign req1_ready = (state == IDLE) & pick1;
  assign resp_hs    = (resp0_valid & resp0_ready) | (resp1_valid & resp1_ready);

  // Both response ports see the same result registers; only valid is per-grant.
  assign resp0_r    = r_q;
  assign resp0_ovf  = ovf_q;
  assign resp1_r    = r_q;
  assign resp1_ovf  = ovf_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      gnt         <= 1'b0;
      calc_op     <= '0;
      calc_a      <= '0;
      calc_b      <= '0;
      r_q         <= '0;
      ovf_q       <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
      ops_done    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            gnt     <= pick1;
            calc_op <= pick1 ? req1_op : req0_op;
            calc_a  <= pick1 ? req1_a  : req0_a;
            calc_b  <= pick1 ? req1_b  : req0_b;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          r_q         <= calc_r;
          ovf_q       <= calc_ovf;
          resp0_valid <= ~gnt;
          resp1_valid <= gnt;
          state       <= RESP;
        end
        RESP: begin
          if (resp_hs) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            last        <= gnt;
            ops_done    <= ops_done + CNT_W'(1);
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: stimulus pushes expected responses into a scoreboard
// queue, and a negedge monitor pops and compares whenever a response is presented.
module tb_calc_arbiter;

  localparam int W     = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_ovf;
  logic req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_ovf;
  logic [2:0] req0_op, req1_op, calc_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, resp0_r, resp1_r;
  logic [W-1:0] calc_a, calc_b, calc_r;
  logic calc_ovf, busy;
  logic [CNT_W-1:0] ops_done;

  always #5 clk = ~clk;

  calc_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_r(resp0_r), .resp0_ovf(resp0_ovf),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_r(resp1_r), .resp1_ovf(resp1_ovf),
    .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
    .calc_r(calc_r), .calc_ovf(calc_ovf),
    .busy(busy), .ops_done(ops_done)
  );

  // Shared calculator: signed add/sub/abs with two's-complement overflow flag.
  logic [W-1:0] x, y;
  always_comb begin
    x = calc_a;
    y = calc_b;
    calc_r   = '0;
    calc_ovf = 1'b0;
    case (calc_op)
      3'b000, 3'b100: begin
        calc_r   = x + y;
        calc_ovf = (x[W-1] == y[W-1]) && (calc_r[W-1] != x[W-1]);
      end
      3'b001: begin
        calc_r   = x - y;
        calc_ovf = (x[W-1] != y[W-1]) && (calc_r[W-1] != x[W-1]);
      end
      3'b101: begin
        calc_r   = y - x;
        calc_ovf = (y[W-1] != x[W-1]) && (calc_r[W-1] != y[W-1]);
      end
      3'b010, 3'b011: begin
        calc_r   = y[W-1] ? -y : y;
        calc_ovf = (y == 4'h8);
      end
      default: begin
        calc_r   = x[W-1] ? -x : x;
        calc_ovf = (x == 4'h8);
      end
    endcase
  end

  typedef struct {
    int           id;
    logic [W-1:0] r;
    logic         ovf;
    int           hs;
  } exp_t;

  exp_t q[$];
  int   gnt_log[$];
  int   ops_log[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   exp_ops = 0;
  bit   ops_pending = 0;
  bit   prev_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid  = 0;
      ops_pending = 0;
    end else begin
      if (ops_pending) begin
        check("ops_done", 32'(ops_done), 32'(exp_ops));
        ops_log.push_back(int'(ops_done));
        ops_pending = 0;
      end
      if (resp0_valid && resp1_valid) check("both_resp_valid", 1, 0);
      if (resp0_valid || resp1_valid) begin
        if (q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          check("resp_id", resp1_valid ? 1 : 0, 32'(q[0].id));
          check("resp_r", resp1_valid ? resp1_r : resp0_r, 32'(q[0].r));
          check("resp_ovf", resp1_valid ? resp1_ovf : resp0_ovf, 32'(q[0].ovf));
          if (!prev_valid) check("resp_latency", 32'(cyc), 32'(q[0].hs + 2));
          if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            void'(q.pop_front());
            exp_ops = (exp_ops + 1) % (1 << CNT_W);
            ops_pending = 1;
          end
        end
      end
      prev_valid = resp0_valid | resp1_valid;
    end
  end

  task automatic drive_req(input int id, input logic v, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Raise a request, wait for its grant, push the expected response.
  task automatic issue(input int id, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic eo,
                       output int waits);
    exp_t e;
    logic rdy;
    waits = 0;
    drive_req(id, 1'b1, op, a, b);
    forever begin
      @(negedge clk);
      rdy = (id == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      waits++;
      if (waits > 200) begin
        check($sformatf("grant_timeout_req%0d", id), 0, 1);
        break;
      end
    end
    if (rdy) begin
      e.id = id; e.r = er; e.ovf = eo; e.hs = cyc;
      q.push_back(e);
      gnt_log.push_back(id);
    end
    @(posedge clk);
    #1;
    drive_req(id, 1'b0, op, a, b);
  endtask

  int w0, w1, w2, w3;
  int exp_gnt[4] = '{0, 1, 0, 1};
  int exp_seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    drive_req(0, 1'b0, 3'b000, '0, '0);
    drive_req(1, 1'b0, 3'b000, '0, '0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
    check("rst_calc", {calc_op, calc_a, calc_b}, 0);
    check("rst_resp_r", {resp0_r, resp0_ovf, resp1_r, resp1_ovf}, 0);
    check("rst_ops_done", 32'(ops_done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready_low", {req0_ready, req1_ready}, 0);

    // Reset during EXEC discards the operation
    issue(0, 3'b000, 4'd1, 4'd1, 4'd2, 1'b0, w0);
    check("exec_busy", busy, 1);
    check("exec_calc", {calc_op, calc_a, calc_b}, {3'b000, 4'd1, 4'd1});
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_calc", {calc_op, calc_a, calc_b}, 0);
    q.delete();
    gnt_log.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_resp", {resp0_valid, resp1_valid}, 0);
    check("midrst_ops_done", 32'(ops_done), 0);
    @(posedge clk);
    #1;

    // Tie arbitration: both requesters keep requests pending
    fork
      begin
        issue(0, 3'b001, 4'd5, 4'd2, 4'd3, 1'b0, w0);         // 5-2 = 3
        issue(0, 3'b100, 4'h8, 4'hF, 4'h7, 1'b1, w1);         // -1+-8 overflows
      end
      begin
        issue(1, 3'b101, 4'd2, 4'hD, 4'hB, 1'b0, w2);         // -3-2 = -5
        issue(1, 3'b110, 4'hB, 4'd0, 4'd5, 1'b0, w3);         // |-5| = 5
      end
    join
    check("tie_grant_count", 32'(gnt_log.size()), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check($sformatf("tie_grant_%0d", i), 32'(gnt_log[i]), 32'(exp_gnt[i]));

    // Single add, granted in the same cycle it is requested
    repeat (4) @(posedge clk);
    #1;
    issue(0, 3'b000, 4'd3, 4'd2, 4'd5, 1'b0, w0);
    check("add_ready_same_cycle", 32'(w0), 0);

    // Overflow cases on requester 1
    repeat (4) @(posedge clk);
    #1;
    issue(1, 3'b000, 4'd7, 4'd1, 4'h8, 1'b1, w0);
    repeat (4) @(posedge clk);
    #1;
    issue(1, 3'b010, 4'd0, 4'h8, 4'h8, 1'b1, w0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure on response 0 while requester 1 waits
    resp0_ready = 1'b0;
    fork
      issue(0, 3'b000, 4'd2, 4'd3, 4'd5, 1'b0, w0);
      begin
        repeat (2) @(negedge clk);
        issue(1, 3'b011, 4'd0, 4'hE, 4'd2, 1'b0, w1);         // |-2| = 2
      end
      begin
        w2 = 0;
        while (!resp0_valid && w2 < 50) begin
          @(negedge clk);
          w2++;
        end
        check("bp_resp_seen", resp0_valid, 1);
        for (int i = 0; i < 5; i++) begin
          check("bp_busy", busy, 1);
          check("bp_req1_ready", req1_ready, 0);
          check("bp_r_stable", {resp0_r, resp0_ovf}, {4'd5, 1'b0});
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_req1_granted_next", req1_ready, 1);
      end
    join

    // Drain
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 0);
    repeat (2) @(negedge clk);
    check("ops_log_len", 32'(ops_log.size() >= 5), 1);
    for (int i = 0; i < 5 && i < ops_log.size(); i++)
      check($sformatf("ops_wrap_%0d", i), 32'(ops_log[i]), 32'(exp_seq[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Round-robin controller that shares one 4-bit combinational calculator (op-coded add/sub/abs unit with `R` and `ovf` outputs) between two requesters. Each requester issues an operation over a valid/ready request channel and receives the registered result and overflow flag over a valid/ready response channel. The block owns sequencing (accept → execute → respond), keeps the calculator inputs stable for a full cycle, and counts completed operations.

## Interface
Parameters:
- `W`, 4, operand/result width; must match the calculator.
- `CNT_W`, 8, width of the completed-operation counter.

Ports:
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `req0_valid` input 1 — requester 0 has an operation.
- `req0_ready` output 1 — request 0 accepted this cycle when high with `req0_valid`.
- `req0_op` input 3 — opcode (000 A+B, 001 A−B, 01x |B|, 100 B+A, 101 B−A, 11x |A|).
- `req0_a`, `req0_b` input W — signed operands.
- `resp0_valid` output 1 — result for requester 0 available.
- `resp0_ready` input 1 — requester 0 consumes the result.
- `resp0_r` output W — result. `resp0_ovf` output 1 — overflow flag.
- `req1_*`, `resp1_*` — identical set for requester 1.
- `calc_op` output 3, `calc_a` output W, `calc_b` output W — drive the shared calculator.
- `calc_r` input W, `calc_ovf` input 1 — calculator outputs (combinational from `calc_*`).
- `busy` output 1 — high in any state other than IDLE.
- `ops_done` output CNT_W — completed responses, wraps modulo 2^CNT_W.

## Operation
- FSM states IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: `reqN_ready` is combinational and asserted only for the granted requester. Grant rule: if exactly one `reqN_valid` is high, grant it; if both are high, grant the requester that is not `last` (`last` resets to 1, so requester 0 wins the first tie). On handshake, latch op/a/b into operand registers, record the grant id, go to EXEC. With no valid request, stay in IDLE and hold `reqN_ready` low.
- EXEC: `calc_op/a/b` = operand registers. At the end of the cycle, capture `calc_r` and `calc_ovf` into the result registers and go to RESP.
- RESP: assert `respG_valid` for the granted id only. `resp_r`/`resp_ovf` stay stable while waiting. On `respG_valid & respG_ready`, set `last` ← G, increment `ops_done`, and go to IDLE.
- `respN_r`/`respN_ovf` drive the result registers to both ports; only the `valid` signals are qualified by grant.
- `calc_*` outputs are the operand registers in all states. They hold their last value outside EXEC.
- No request is accepted outside IDLE. A requester asserting valid during EXEC/RESP waits, and must hold its request stable until ready.
- The block does not interpret opcodes; overflow semantics are the calculator's, passed through unmodified.

## Timing
- Reset values: all `ready`/`valid` outputs 0, `busy` 0, `calc_op/a/b` 0, `resp*_r` 0, `resp*_ovf` 0, `ops_done` 0, `last` 1.
- Reset asserted in any state: return to IDLE immediately (asynchronously); any in-flight operation is discarded with no response and no count.
- Latency: request handshake in cycle N → `respG_valid` high in cycle N+2.
- Minimum issue interval: 3 cycles, when the response is consumed in its first valid cycle.
- A same-cycle response handshake and new `reqN_valid` are legal. The new request is granted no earlier than the next cycle (IDLE), using the updated `last`.
- `ops_done` wraps from 2^CNT_W−1 to 0 without a flag.

## Test plan
- Single add: req0 op=000, a=3, b=2 → `req0_ready` 1 in the same cycle; `resp0_valid` 2 cycles later with r=5, ovf=0; `ops_done`=1.
- Overflow: req1 op=000, a=7, b=1 → `resp1_r`=4'b1000 (−8), `resp1_ovf`=1. Then op=01x, b=−8 → response flag matches the calculator model.
- Tie arbitration: both valid continuously from reset with distinct ops → grants alternate 0,1,0,1. Each response appears only on the matching `respN_valid`.
- Backpressure: hold `resp0_ready` low for 5 cycles in RESP → r/ovf stable, `busy`=1, `req1_ready` stays 0. Release → IDLE, then req1 is granted next cycle.
- Reset mid-EXEC: assert `rst` during EXEC → all outputs at reset values immediately, no response after release, `ops_done` unchanged at 0.
- Counter wrap (CNT_W=2): complete 5 operations → `ops_done` sequence 1,2,3,0,1.
